// File: rtl/power_spectrum.sv
// power_spectrum
//   Streaming |X[k]|^2 stage for the complex FFT output path. Accepts one
//   complex Q1.15 bin per beat in natural order 0..N-1 and forwards only the
//   one-sided spectrum (bins 0..N/2) as unsigned Q2.30 power, together with
//   the bin index and an end-of-frame marker. Upstream last flags are checked
//   against the local bin counter; a mismatch resynchronises the counter and
//   raises a one-cycle frame_err pulse.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_re, in_im          signed Q1.15 components
//   in_last               upstream marks bin N-1
//   out_valid/out_ready   output handshake
//   out_pow               unsigned Q2.30 re^2 + im^2
//   out_bin               bin index 0..N/2
//   out_last              high on the bin N/2 beat
//   frame_err             one-cycle pulse per misaligned beat
module power_spectrum #(
  parameter int WIDTH = 16,
  parameter int N     = 512,
  parameter int BW    = $clog2(N/2+1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_pow,
  output logic [BW-1:0]           out_bin,
  output logic                    out_last,
  output logic                    frame_err
);

  localparam int CW = $clog2(N);
  localparam int PW = 2*WIDTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(N-1);
  localparam logic [CW-1:0] HALF    = CW'(N/2);

  // Full-precision signed square; (-2^(W-1))^2 = 2^(2W-2) still fits in PW bits.
  function automatic logic signed [PW-1:0] square(input logic signed [WIDTH-1:0] x);
    logic signed [PW-1:0] xe;
    xe = PW'(x);
    return xe * xe;
  endfunction

  logic                 advance;
  logic                 accept;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 vld_p1_q, vld_p1_d;
  logic signed [PW-1:0] sq_re_p1_q, sq_re_p1_d;
  logic signed [PW-1:0] sq_im_p1_q, sq_im_p1_d;
  logic [BW-1:0]        bin_p1_q, bin_p1_d;
  logic                 last_p1_q, last_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic [PW-1:0]        pow_p2_q, pow_p2_d;
  logic [BW-1:0]        bin_p2_q, bin_p2_d;
  logic                 last_p2_q, last_p2_d;

  always_comb begin
    advance  = !(vld_p2_q && !out_ready);
    in_ready = advance && !reset;
    accept   = in_valid && in_ready;

    cnt_d      = cnt_q;
    err_d      = 1'b0;
    vld_p1_d   = vld_p1_q;
    sq_re_p1_d = sq_re_p1_q;
    sq_im_p1_d = sq_im_p1_q;
    bin_p1_d   = bin_p1_q;
    last_p1_d  = last_p1_q;
    vld_p2_d   = vld_p2_q;
    pow_p2_d   = pow_p2_q;
    bin_p2_d   = bin_p2_q;
    last_p2_d  = last_p2_q;

    // Frame alignment: a last flag must coincide with bin N-1. Either kind of
    // disagreement restarts the count at bin 0 for the next beat.
    if (accept) begin
      if (in_last != (cnt_q == CNT_MAX)) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (advance) begin
      // Stage 1: squares; upper half of the spectrum is accepted but dropped
      vld_p1_d   = accept && (cnt_q <= HALF);
      sq_re_p1_d = square(in_re);
      sq_im_p1_d = square(in_im);
      bin_p1_d   = BW'(cnt_q);
      last_p1_d  = (cnt_q == HALF);
      // Stage 2: both squares are non-negative, so the unsigned sum is exact
      vld_p2_d   = vld_p1_q;
      pow_p2_d   = $unsigned(sq_re_p1_q) + $unsigned(sq_im_p1_q);
      bin_p2_d   = bin_p1_q;
      last_p2_d  = last_p1_q && vld_p1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      pow_p2_q  <= '0;
      bin_p2_q  <= '0;
      last_p2_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      pow_p2_q  <= pow_p2_d;
      bin_p2_q  <= bin_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  // Stage-1 data is qualified by vld_p1_q, so it carries no reset.
  always_ff @(posedge clock) begin
    sq_re_p1_q <= sq_re_p1_d;
    sq_im_p1_q <= sq_im_p1_d;
    bin_p1_q   <= bin_p1_d;
    last_p1_q  <= last_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_pow   = pow_p2_q;
  assign out_bin   = bin_p2_q;
  assign out_last  = last_p2_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_power_spectrum.sv
module tb_power_spectrum;

  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int BW    = $clog2(N/2+1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_re = '0;
  logic [WIDTH-1:0]  in_im = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*WIDTH-1:0] out_pow;
  logic [BW-1:0]     out_bin;
  logic              out_last;
  logic              frame_err;

  power_spectrum #(.WIDTH(WIDTH), .N(N), .BW(BW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pow(out_pow), .out_bin(out_bin), .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pow;
    logic [2:0]  bin;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cnt_m = 0;
  int   err_exp = 0;
  int   err_seen = 0;
  bit   lat_chk = 0;
  bit   rnd_mode = 0;
  bit   hold_rdy = 1;

  always @(posedge clock) cyc++;

  // Single driver of out_ready: constant level or random 50% duty.
  always @(posedge clock) begin
    #1;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : hold_rdy;
  end

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: in_ready=%b required 0 at cyc %0d", in_ready, cyc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: bin=%0d pow=%h with empty scoreboard", out_bin, out_pow);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_pow !== e.pow || out_bin !== e.bin || out_last !== e.last) begin
            errors++;
            $display("FAIL out_beat: got bin=%0d pow=%h last=%b, required bin=%0d pow=%h last=%b",
                     out_bin, out_pow, out_last, e.bin, e.pow, e.last);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL latency: got %0d cycles, required 2", cyc - e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im,
                      input logic last, input logic [31:0] pw);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    in_last = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        done = 1;
        if (cnt_m <= N/2) begin
          exp_t e;
          e.pow = pw;
          e.bin = 3'(cnt_m);
          e.last = (cnt_m == N/2);
          e.cyc = cyc;
          exp_q.push_back(e);
        end
        if ((last && cnt_m != N-1) || (!last && cnt_m == N-1)) begin
          cnt_m = 0;
          err_exp++;
        end else begin
          cnt_m = (cnt_m + 1) % N;
        end
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
    end
  endtask

  // Ramp bin k: re = k*0x1000, im = 0, power = k^2 * 0x0100_0000.
  task automatic ramp_beat(input int k, input logic last);
    send(16'(k * 16'h1000), 16'h0000, last, 32'(k * k) << 24);
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < N; k++) ramp_beat(k, k == N-1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    checks++;
    if (err_seen != err_exp) begin
      errors++;
      $display("FAIL %s_frame_err: saw %0d pulses, required %0d", name, err_seen, err_exp);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_pow !== 32'h0 || out_bin !== 3'd0 ||
        out_last !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b pow=%h bin=%0d last=%b err=%b, required all 0",
               name, out_valid, out_pow, out_bin, out_last, frame_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset_state");
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Full-rate ramp frame with latency check
    lat_chk = 1;
    ramp_frame();
    drain("ramp");
    lat_chk = 0;

    // Extremes
    send(16'h8000, 16'h8000, 1'b0, 32'h8000_0000);
    send(16'h7FFF, 16'h8001, 1'b0, 32'h7FFE_0002);
    send(16'hFFFF, 16'h0001, 1'b0, 32'h0000_0002);
    send(16'h7FFF, 16'h0000, 1'b0, 32'h3FFF_0001);
    send(16'h0000, 16'h8000, 1'b0, 32'h4000_0000);
    send(16'h1234, 16'h5678, 1'b0, 32'h0);
    send(16'h1234, 16'h5678, 1'b0, 32'h0);
    send(16'h1234, 16'h5678, 1'b1, 32'h0);
    drain("extremes");

    // Random backpressure over 4 frames
    rnd_mode = 1;
    repeat (4) ramp_frame();
    drain("backpressure");
    rnd_mode = 0;

    // Early last on bin 5
    for (int k = 0; k < 5; k++) ramp_beat(k, 1'b0);
    ramp_beat(5, 1'b1);
    ramp_frame();
    drain("early_last");

    // Missing last on bin 7
    for (int k = 0; k < N; k++) ramp_beat(k, 1'b0);
    ramp_frame();
    drain("missing_last");

    // Reset mid-frame while stalled
    for (int k = 0; k < 4; k++) ramp_beat(k, 1'b0);
    hold_rdy = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    @(negedge clock);
    check_idle("mid_reset");
    hold_rdy = 1;
    @(posedge clock);
    #1;
    ramp_frame();
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_spectrum.md
Name: power_spectrum

Overview:
- Streaming |X[k]|^2 stage directly downstream of the Q1.15 complex multiplier (FFT twiddle/butterfly output path).
- Consumes one complex Q1.15 bin per accepted beat in natural order 0..N-1.
- Forwards only the one-sided spectrum, bins 0..N/2, as unsigned Q2.30 power values to the mel filterbank, with bin index and end-of-frame marker.
- Tracks frame alignment against an upstream last flag and resynchronises on mismatch.

Parameters:
- WIDTH, 16, input component width (signed Q1.15).
- N, 512, FFT length; power of 2, >= 4.
- BW, $clog2(N/2+1), width of out_bin.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage accepts a beat this cycle.
- in_re  in  WIDTH  signed Q1.15 real part.
- in_im  in  WIDTH  signed Q1.15 imag part.
- in_last  in  1  upstream marks bin N-1 of the frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_pow  out  2*WIDTH  unsigned Q2.30, re^2 + im^2.
- out_bin  out  BW  bin index, 0..N/2.
- out_last  out  1  high on the bin N/2 output beat.
- frame_err  out  1  one-cycle pulse on frame misalignment.

Behaviour:
- Beat transfer happens only when valid and ready are both high on the same rising edge; this rule applies to both interfaces.
- Pipeline:
  - Stage 1 registers re*re and im*im as signed 2*WIDTH products, together with the bin index and last flag.
  - Stage 2 registers the unsigned sum as out_pow.
- Latency: 2 cycles from input accept to out_valid when no stall.
- Stall: advance = !(out_valid && !out_ready). Both stages hold while the output is stalled.
- in_ready = advance && !reset (combinational). A stall never drops or duplicates a beat.
- Arithmetic:
  - Each square is non-negative.
  - The sum is at most 2^31 (both inputs -32768), so 2*WIDTH unsigned bits hold it exactly. No rounding, no saturation.
  - Examples: 0x8000 with 0x8000 gives 0x8000_0000; 0x7FFF with 0 gives 0x3FFF_0001.
- Bin counter cnt (log2 N bits):
  - Increments on every accepted beat and wraps from N-1 to 0.
  - Beats with cnt <= N/2 enter the pipeline with bin = cnt.
  - Beats with cnt > N/2 are accepted but discarded. No pipeline valid is generated, so there are no output bubbles for them.
- out_last = 1 exactly when out_bin == N/2 on a valid output beat.
- Frame check, evaluated on each accepted beat:
  - in_last=1 with cnt != N-1: cnt goes to 0 next cycle and frame_err pulses.
  - in_last=0 with cnt == N-1: cnt wraps to 0 as normal and frame_err pulses.
  - The beat that triggers the check is itself processed or discarded normally.
- frame_err is registered and high for exactly one cycle per offending beat.
- Reset (synchronous, any time including mid-frame or mid-stall):
  - Clears cnt, both stage valids, out_valid, out_pow, out_bin, out_last and frame_err to 0.
  - In-flight beats are lost; the first beat accepted after reset is bin 0.
- Outputs hold their values while out_valid && !out_ready. out_pow, out_bin and out_last are don't-care when out_valid=0, except that after reset they are 0.
- Simultaneous events: an input accept and an output accept in the same cycle are a normal streaming beat, giving 1 beat/cycle sustained throughput.

Test Plan:
- Full-rate frame, N=8, out_ready=1, bins k with re=k*0x1000, im=0. Outputs appear on cycles 2..6 with out_bin 0..4 and out_pow = k^2*0x0100_0000. out_last only on bin 4. Bins 5..7 produce no output. frame_err stays 0.
- Extremes: (0x8000,0x8000) -> 0x8000_0000; (0x7FFF,0x8001) -> 0x7FFE_0002; (0xFFFF,0x0001) -> 0x0000_0002.
- Backpressure: random out_ready with 50% duty over 4 frames. The output sequence must be bit-identical to the no-stall run, with no loss or duplicate. in_ready must be low in every cycle where out_valid && !out_ready.
- Early in_last on bin 5 (N=8): frame_err pulses once. The next accepted beat is emitted as out_bin 0.
- Missing in_last on bin 7: frame_err pulses once. The counter still wraps and the next frame outputs bins 0..4 correctly.
- Reset asserted for 1 cycle mid-frame (after bin 3) while a stall is active: out_valid=0 the next cycle and all outputs are 0. The following frame starts at out_bin 0 with correct powers.
